// File: rtl/max_pool_3.sv
// 2x2/stride-2 signed max-pool sequencer: reads each window from a source BRAM
// and writes one pooled word per window into the max_pool_3 BRAM.
module max_pool_3_ctrl #(
  parameter int unsigned IN_W = 8,
  parameter int unsigned IN_H = 8,
  parameter int unsigned CH   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] src_base,
  input  logic [31:0] dst_base,
  output logic [31:0] src_addr,
  output logic        src_en,
  input  logic [31:0] src_dout,
  output logic [31:0] dst_addr,
  output logic [31:0] dst_din,
  output logic        dst_en,
  output logic [3:0]  dst_we,
  output logic        busy,
  output logic        done
);

  localparam int unsigned OW   = IN_W / 2;
  localparam int unsigned OH   = IN_H / 2;
  localparam int unsigned OXW  = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned OYW  = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned MAP  = IN_W * IN_H;
  localparam int unsigned OMAP = OW * OH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [1:0]     k_q, k_d;
  logic [OXW-1:0] ox_q, ox_d;
  logic [OYW-1:0] oy_q, oy_d;
  logic [CW-1:0]  c_q, c_d;
  logic [31:0]    src_base_q, src_base_d;
  logic [31:0]    dst_base_q, dst_base_d;
  logic [31:0]    max_q, max_d;

  logic [31:0] src_addr_q, src_addr_d;
  logic        src_en_q, src_en_d;
  logic [31:0] dst_addr_q, dst_addr_d;
  logic [31:0] dst_din_q, dst_din_d;
  logic        dst_en_q, dst_en_d;
  logic [3:0]  dst_we_q, dst_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        last_win;
  logic        gt;
  logic [31:0] src_idx;
  logic [31:0] dst_idx;

  // Next-state, counters, running max, then registered-output decode of the next state
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    c_d        = c_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    max_d      = max_q;

    last_win = (c_q == CW'(CH - 1)) && (oy_q == OYW'(OH - 1)) && (ox_q == OXW'(OW - 1));
    gt       = $signed(src_dout) > $signed(max_q);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_READ;
          k_d        = 2'd0;
          ox_d       = '0;
          oy_d       = '0;
          c_d        = '0;
          max_d      = '0;
          src_base_d = src_base;
          dst_base_d = dst_base;
        end
      end
      S_READ: begin
        // Read data lags the address by one cycle, so capture k-1's word here
        if (k_q == 2'd1) begin
          max_d = src_dout;
        end else if (k_q != 2'd0 && gt) begin
          max_d = src_dout;
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (k_q == 2'd3) begin
          state_d = S_DRAIN;
          k_d     = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (gt) begin
          max_d = src_dout;
        end
        state_d = abort ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_win) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          k_d     = 2'd0;
          if (ox_q == OXW'(OW - 1)) begin
            ox_d = '0;
            if (oy_q == OYW'(OH - 1)) begin
              oy_d = '0;
              c_d  = c_q + CW'(1);
            end else begin
              oy_d = oy_q + OYW'(1);
            end
          end else begin
            ox_d = ox_q + OXW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    src_idx = 32'(c_d) * 32'(MAP)
            + ((32'(oy_d) << 1) + 32'(k_d[1])) * 32'(IN_W)
            + (32'(ox_d) << 1) + 32'(k_d[0]);
    dst_idx = 32'(c_d) * 32'(OMAP) + 32'(oy_d) * 32'(OW) + 32'(ox_d);

    src_en_d   = (state_d == S_READ);
    src_addr_d = src_en_d ? (src_base_d + (src_idx << 2)) : 32'd0;
    dst_en_d   = (state_d == S_WRITE);
    dst_we_d   = dst_en_d ? 4'hF : 4'h0;
    dst_addr_d = dst_en_d ? (dst_base_d + (dst_idx << 2)) : 32'd0;
    dst_din_d  = dst_en_d ? max_d : 32'd0;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      c_q        <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      max_q      <= '0;
      src_addr_q <= '0;
      src_en_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_din_q  <= '0;
      dst_en_q   <= 1'b0;
      dst_we_q   <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      c_q        <= c_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      max_q      <= max_d;
      src_addr_q <= src_addr_d;
      src_en_q   <= src_en_d;
      dst_addr_q <= dst_addr_d;
      dst_din_q  <= dst_din_d;
      dst_en_q   <= dst_en_d;
      dst_we_q   <= dst_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign src_addr = src_addr_q;
  assign src_en   = src_en_q;
  assign dst_addr = dst_addr_q;
  assign dst_din  = dst_din_q;
  assign dst_en   = dst_en_q;
  assign dst_we   = dst_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/max_pool_3_ctrl.md
MAX_POOL_3_CTRL -- requirements
Module: max_pool_3_ctrl

Interface
REQ-001 Parameter IN_W, default 8: input feature-map width in pixels; even, at least 2.
REQ-002 Parameter IN_H, default 8: input feature-map height in pixels; even, at least 2.
REQ-003 Parameter CH, default 64: number of channels.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: single-cycle request to pool one full feature map.
REQ-007 Port abort, input, 1: terminate the current job.
REQ-008 Port src_base, input, 32: byte address of the source map; latched on accepted start.
REQ-009 Port dst_base, input, 32: byte address of the destination in max_pool_3 BRAM; latched on accepted start.
REQ-010 Ports src_addr (output, 32), src_en (output, 1), src_dout (input, 32): source BRAM read port, one-cycle read latency.
REQ-011 Ports dst_addr (output, 32), dst_din (output, 32), dst_en (output, 1), dst_we (output, 4): drive max_pool_3 BRAM port A.
REQ-012 Port busy, output, 1: job in progress.
REQ-013 Port done, output, 1: one-cycle pulse when a job completes normally.

Function
REQ-014 Data: one signed 32-bit value per word; all addresses are byte addresses (word index x 4).
REQ-015 Source index = c*IN_H*IN_W + y*IN_W + x; destination index = c*(IN_H/2)*(IN_W/2) + oy*(IN_W/2) + ox.
REQ-016 Operation: 2x2 window, stride 2; output = signed maximum of the window; a tie keeps the first-read value.
REQ-017 Iteration order: ox fastest, then oy, then c.
REQ-018 Window read order: (2oy,2ox), (2oy,2ox+1), (2oy+1,2ox), (2oy+1,2ox+1).
REQ-019 FSM states:
- IDLE
- READ: 4 cycles, counter k = 0..3
- DRAIN: 1 cycle
- WRITE: 1 cycle
- DONE: 1 cycle
REQ-020 IDLE -> READ on start; base addresses latched and all counters cleared in that same cycle.
REQ-021 In READ, src_en = 1 and src_addr = src_base + 4*index of window element k.
REQ-022 Running max: src_dout is captured the cycle after each read.
- The first capture loads the register unconditionally.
- Later captures replace it only if strictly greater (signed).
REQ-023 READ(k=3) -> DRAIN; DRAIN captures the fourth value.
REQ-024 DRAIN -> WRITE; in WRITE, dst_en = 1, dst_we = 4'hF, dst_din = running max, dst_addr = dst_base + 4*destination index.
REQ-025 WRITE -> READ for the next window, or -> DONE after the last window (c=CH-1, oy=IN_H/2-1, ox=IN_W/2-1).
REQ-026 DONE -> IDLE; done = 1 only in DONE.
REQ-027 Latency: exactly 6 cycles per output.
- First write occurs 6 cycles after the start cycle.
- done pulses 6*CH*(IN_H/2)*(IN_W/2)+1 cycles after the start cycle.
REQ-028 busy = 1 in READ, DRAIN, WRITE and DONE; busy = 0 in IDLE.
REQ-029 src_en, dst_en and dst_we are 0 in every cycle not listed in REQ-021 and REQ-024.
REQ-030 A start while busy is ignored and does not alter the latched base addresses or counters.
REQ-031 abort while busy:
- Next state is IDLE; done is not pulsed.
- If abort falls in a WRITE cycle, that write completes; no further writes occur.
REQ-032 abort and start together in IDLE: abort wins and the job is not started.
REQ-033 Counters wrap only through REQ-025; no address is produced outside the source or destination map ranges.

Reset
REQ-034 rst_n low forces, asynchronously:
- state to IDLE
- all counters and the running max to 0
- busy, done, src_en, dst_en to 0; dst_we to 4'h0; src_addr, dst_addr, dst_din to 0
REQ-035 Reset asserted mid-job discards the job; after release the block waits in IDLE for a new start.

Verification
REQ-036 IN_W=4, IN_H=4, CH=1, source = 0..15, src_base=0, dst_base=0x100:
- writes 5, 7, 13, 15 to 0x100, 0x104, 0x108, 0x10C
- done pulses 25 cycles after start
REQ-037 Negative data, window {-5, -2, -9, -2}: result is -2 (signed compare; tie keeps first occurrence).
REQ-038 start pulsed again 3 cycles after the first start, with a different src_base: output addresses and values are unchanged from REQ-036.
REQ-039 abort asserted in the 8th cycle after start: exactly one write occurs (at 0x100); busy falls next cycle; done never pulses.
REQ-040 rst_n pulled low mid-READ:
- src_en, dst_en and busy are 0 immediately
- a subsequent start reproduces REQ-036 exactly
REQ-041 Default parameters, random data:
- 1024 writes, checked against a reference model
- done at cycle 6145 after start
- no src_en/dst_en outside the stated states
